// File: rtl/zuse_fp_mul.sv
// zuse_fp_mul: sequential sign/exponent/mantissa multiplier for the tinyZuse FPU.
// A radix-2 shift-add core resolves one multiplier bit per clock. The product is
// then normalised, classified (zero / overflow / underflow) and published through
// a registered output stage. The output stage makes done and idle registered
// signals, and it puts the results MANT_W+2 edges after the start edge.
module zuse_fp_mul #(
  parameter int EXP_W  = 7,
  parameter int MANT_W = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              a_s,
  input  logic [EXP_W-1:0]  a_e,
  input  logic [MANT_W-1:0] a_m,
  input  logic              b_s,
  input  logic [EXP_W-1:0]  b_e,
  input  logic [MANT_W-1:0] b_m,
  output logic              res_s,
  output logic [EXP_W-1:0]  res_e,
  output logic [MANT_W-1:0] res_m,
  output logic              zero_flag,
  output logic              ovf_flag,
  output logic              unf_flag,
  output logic              idle,
  output logic              done
);

  // state  | meaning
  // S_IDLE | waiting for start (accepted only while idle is high)
  // S_CALC | shift-add, one multiplier bit per clock, MANT_W clocks
  // S_NORM | normalise and classify the product into the output stage
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_NORM} state_t;

  localparam int P_W   = 2 * MANT_W;
  localparam int CNT_W = $clog2(MANT_W);
  localparam logic signed [EXP_W:0] E_MAX = (EXP_W+1)'((2 ** (EXP_W-1)) - 1);
  localparam logic signed [EXP_W:0] E_MIN = -(EXP_W+1)'(2 ** (EXP_W-1));

  state_t r_state;
  state_t w_state_nxt;

  logic [P_W-1:0]          r_acc;
  logic [P_W-1:0]          r_mcand;
  logic [MANT_W-1:0]       r_mplr;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_sign;
  logic signed [EXP_W:0]   r_esum;
  logic                    r_zero_op;

  logic                    r_nrm_vld;
  logic                    r_nrm_s;
  logic [EXP_W-1:0]        r_nrm_e;
  logic [MANT_W-1:0]       r_nrm_m;
  logic                    r_nrm_zero;
  logic                    r_nrm_ovf;
  logic                    r_nrm_unf;
  logic                    r_idle;
  logic                    r_done;

  logic                    w_accept;
  logic                    w_p_top;
  logic [MANT_W-1:0]       w_m_norm;
  logic signed [EXP_W:0]   w_esum_norm;
  logic                    w_ovf;
  logic                    w_unf;
  logic                    w_res_s;
  logic [EXP_W-1:0]        w_res_e;
  logic [MANT_W-1:0]       w_res_m;
  logic                    w_res_zero;
  logic                    w_unused_lsb;

  // r_idle stays low until the output stage publishes, so a start in the gap is ignored.
  assign w_accept = (r_state == S_IDLE) && r_idle && start;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == '0) w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch and shift-add mantissa core.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_esum    <= '0;
      r_zero_op <= 1'b0;
    end else if (w_accept) begin
      r_acc     <= '0;
      r_mcand   <= {{MANT_W{1'b0}}, a_m};
      r_mplr    <= b_m;
      r_cnt     <= CNT_W'(MANT_W - 1);
      r_sign    <= a_s ^ b_s;
      r_esum    <= $signed({a_e[EXP_W-1], a_e}) + $signed({b_e[EXP_W-1], b_e});
      r_zero_op <= ~a_m[MANT_W-1] | ~b_m[MANT_W-1];
    end else if (r_state == S_CALC) begin
      if (r_mplr[0]) r_acc <= r_acc + r_mcand;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  // Normalise (truncating) and classify; zero operands win over range checks.
  always_comb begin
    w_p_top     = r_acc[P_W-1];
    w_m_norm    = w_p_top ? r_acc[P_W-1:MANT_W] : r_acc[P_W-2:MANT_W-1];
    w_esum_norm = r_esum + $signed({{EXP_W{1'b0}}, w_p_top});
    w_ovf       = 1'b0;
    w_unf       = 1'b0;
    w_res_zero  = 1'b0;
    w_res_s     = 1'b0;
    w_res_e     = '0;
    w_res_m     = '0;
    if (r_zero_op) begin
      w_res_zero = 1'b1;
    end else if (w_esum_norm > E_MAX) begin
      w_ovf   = 1'b1;
      w_res_s = r_sign;
      w_res_e = E_MAX[EXP_W-1:0];
      w_res_m = '1;
    end else if (w_esum_norm < E_MIN) begin
      w_unf      = 1'b1;
      w_res_zero = 1'b1;
    end else begin
      w_res_s = r_sign;
      w_res_e = w_esum_norm[EXP_W-1:0];
      w_res_m = w_m_norm;
    end
  end

  // Truncated product bits are intentionally discarded.
  assign w_unused_lsb = ^r_acc[MANT_W-2:0];

  // Capture the normalised result at the end of the NORM cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_nrm_vld  <= 1'b0;
      r_nrm_s    <= 1'b0;
      r_nrm_e    <= '0;
      r_nrm_m    <= '0;
      r_nrm_zero <= 1'b0;
      r_nrm_ovf  <= 1'b0;
      r_nrm_unf  <= 1'b0;
    end else begin
      r_nrm_vld <= (r_state == S_NORM);
      if (r_state == S_NORM) begin
        r_nrm_s    <= w_res_s;
        r_nrm_e    <= w_res_e;
        r_nrm_m    <= w_res_m;
        r_nrm_zero <= w_res_zero;
        r_nrm_ovf  <= w_ovf;
        r_nrm_unf  <= w_unf;
      end
    end
  end

  // Publish results, pulse done and reopen idle in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_s     <= 1'b0;
      res_e     <= '0;
      res_m     <= '0;
      zero_flag <= 1'b0;
      ovf_flag  <= 1'b0;
      unf_flag  <= 1'b0;
      r_done    <= 1'b0;
      r_idle    <= 1'b1;
    end else begin
      r_done <= r_nrm_vld;
      if (w_accept)       r_idle <= 1'b0;
      else if (r_nrm_vld) r_idle <= 1'b1;
      if (r_nrm_vld) begin
        res_s     <= r_nrm_s;
        res_e     <= r_nrm_e;
        res_m     <= r_nrm_m;
        zero_flag <= r_nrm_zero;
        ovf_flag  <= r_nrm_ovf;
        unf_flag  <= r_nrm_unf;
      end
    end
  end

  assign idle = r_idle;
  assign done = r_done;

endmodule
